// File: rtl/fifo_op_sched.sv
// fifo_op_sched: host-bus decode and compute scheduler for the A/B/Y FIFO
// datapath. Pops one A and one B operand, combines them with OP, and pushes
// the result into Y. Holds only FSM state, the read register, the sticky
// error flag and the saturating result counter.
//
// Host handshake: write_en/read_en are single-cycle strobes; write_rdy and
// read_rdy are high in every cycle except a reset cycle, so a strobe with
// rdy=1 is always consumed in that same cycle (writes take effect at the
// edge, read_data updates on the edge after read_en).
module fifo_op_sched #(
  parameter int OP    = 0,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       write_address,
  input  logic             write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [2:0]       read_address,
  input  logic             read_en,
  output logic             read_data,
  output logic             read_rdy,
  output logic             a_enq,
  output logic             a_deq,
  output logic             a_clr,
  output logic             a_din,
  input  logic             a_dout,
  input  logic             a_full_n,
  input  logic             a_empty_n,
  output logic             b_enq,
  output logic             b_deq,
  output logic             b_clr,
  output logic             b_din,
  input  logic             b_dout,
  input  logic             b_full_n,
  input  logic             b_empty_n,
  output logic             y_enq,
  output logic             y_deq,
  output logic             y_clr,
  output logic             y_din,
  input  logic             y_dout,
  input  logic             y_full_n,
  input  logic             y_empty_n,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] result_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FIRE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             read_data_q, read_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic clr_cmd;
  logic wr_a, wr_b, rd_y;
  logic fire;
  logic ovf, und;
  logic op_res;

  // Combine function applied to the two FIFO heads; reserved code falls back to OR.
  always_comb begin
    op_res = a_dout | b_dout;
    case (OP)
      1:       op_res = a_dout & b_dout;
      2:       op_res = a_dout ^ b_dout;
      default: op_res = a_dout | b_dout;
    endcase
  end

  // Bus decode: a clear, or reset, suppresses every enqueue/dequeue this cycle.
  always_comb begin
    clr_cmd = !RST && write_en && (write_address == 3'd6) && write_data;
    wr_a    = !RST && !clr_cmd && write_en && (write_address == 3'd4);
    wr_b    = !RST && !clr_cmd && write_en && (write_address == 3'd5);
    rd_y    = !RST && !clr_cmd && read_en  && (read_address  == 3'd3);
    fire    = !RST && !clr_cmd && (state_q == FIRE);
    ovf     = (wr_a && !a_full_n) || (wr_b && !b_full_n);
    und     = rd_y && !y_empty_n;
  end

  // FIFO strobe and data drive.
  always_comb begin
    a_enq = wr_a && a_full_n;
    a_din = a_enq && write_data;
    b_enq = wr_b && b_full_n;
    b_din = b_enq && write_data;
    a_deq = fire;
    b_deq = fire;
    y_enq = fire;
    y_din = fire && op_res;
    y_deq = rd_y && y_empty_n;
    a_clr = clr_cmd;
    b_clr = clr_cmd;
    y_clr = clr_cmd;
  end

  // FSM next state: FIRE always lasts exactly one cycle so FIFO flags settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (a_empty_n && b_empty_n && y_full_n && !clr_cmd) state_d = FIRE;
      FIRE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read register, sticky error and saturating counter next values.
  always_comb begin
    read_data_d = read_data_q;
    if (read_en) begin
      case (read_address)
        3'd0:    read_data_d = a_full_n;
        3'd1:    read_data_d = b_full_n;
        3'd2:    read_data_d = y_empty_n;
        3'd3:    read_data_d = y_empty_n && y_dout;
        3'd4:    read_data_d = err_q;
        3'd5:    read_data_d = (state_q == FIRE);
        default: read_data_d = 1'b0;
      endcase
    end

    err_d = err_q;
    if (clr_cmd)         err_d = 1'b0;
    else if (ovf || und) err_d = 1'b1;

    cnt_d = cnt_q;
    if (clr_cmd)                 cnt_d = '0;
    else if (fire && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      read_data_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign write_rdy    = !RST;
  assign read_rdy     = !RST;
  assign read_data    = read_data_q;
  assign err          = err_q;
  assign busy         = (state_q == FIRE);
  assign result_count = cnt_q;

endmodule
